// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions: hazard FSM states, the hard-wired zero register
// and the load-use hazard detect function.
package core_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load targeting x0 never forwards anything, so it cannot create a hazard.
   function automatic logic is_load_use(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
      return mem_read & (rd != REG_ZERO) & ((rd == rs1) | (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard scheduler; master drives the
// stage information, slave (the scheduler) returns stall/flush controls.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_br_taken;
   logic             mem_req;
   logic             mem_ack;
   logic             ctrl_stall;
   logic             pc_hold;
   logic             if_id_hold;
   logic             if_id_flush;
   logic             id_ex_hold;
   logic             ex_mem_hold;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             mem_timeout;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_br_taken, mem_req, mem_ack,
      input  ctrl_stall, pc_hold, if_id_hold, if_id_flush, id_ex_hold, ex_mem_hold,
      input  stall_cnt, flush_cnt, mem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_br_taken, mem_req, mem_ack,
      output ctrl_stall, pc_hold, if_id_hold, if_id_flush, id_ex_hold, ex_mem_hold,
      output stall_cnt, flush_cnt, mem_timeout
   );
endinterface

// File: rtl/hazard_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler: same-cycle stall, hold and flush controls for the
// 5-stage pipeline, with perf counters and a sticky memory-timeout flag.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int MEM_TMO    = 255,
   parameter int CNT_W      = 16
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.slave  bus
);
   hz_state_e        state_q, state_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;

   logic hazard_s;
   logic memwait_s;
   logic ctrl_stall_s, pc_hold_s, if_id_hold_s, if_id_flush_s, id_ex_hold_s, ex_mem_hold_s;

   assign hazard_s  = is_load_use(bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_rs2);
   assign memwait_s = bus.mem_req & ~bus.mem_ack;

   // Next-state and Mealy controls; memory wait outranks branch, branch outranks load-use.
   always_comb begin
      state_d       = state_q;
      lu_cnt_d      = lu_cnt_q;
      ctrl_stall_s  = 1'b0;
      pc_hold_s     = 1'b0;
      if_id_hold_s  = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_hold_s  = 1'b0;
      ex_mem_hold_s = 1'b0;
      if (memwait_s) begin
         pc_hold_s     = 1'b1;
         if_id_hold_s  = 1'b1;
         id_ex_hold_s  = 1'b1;
         ex_mem_hold_s = 1'b1;
         if (state_q == RUN) begin
            state_d = MEM_WAIT;
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            MEM_WAIT: begin
               // Release cycle: every hold drops so the frozen stages advance together.
               state_d = RUN;
               if (bus.ex_br_taken) begin
                  if_id_flush_s = 1'b1;
                  ctrl_stall_s  = 1'b1;
               end else begin
                  if_id_flush_s = 1'b0;
               end
            end
            LU_STALL: begin
               if (bus.ex_br_taken) begin
                  if_id_flush_s = 1'b1;
                  ctrl_stall_s  = 1'b1;
                  state_d       = RUN;
                  lu_cnt_d      = 2'd0;
               end else begin
                  pc_hold_s    = 1'b1;
                  if_id_hold_s = 1'b1;
                  ctrl_stall_s = 1'b1;
                  lu_cnt_d     = lu_cnt_q - 2'd1;
                  if (lu_cnt_q == 2'd1) begin
                     state_d = RUN;
                  end else begin
                     state_d = LU_STALL;
                  end
               end
            end
            default: begin
               if (bus.ex_br_taken) begin
                  if_id_flush_s = 1'b1;
                  ctrl_stall_s  = 1'b1;
               end else if (hazard_s) begin
                  pc_hold_s    = 1'b1;
                  if_id_hold_s = 1'b1;
                  ctrl_stall_s = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     state_d  = LU_STALL;
                     lu_cnt_d = 2'(LU_BUBBLES - 1);
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  state_d = RUN;
               end
            end
         endcase
      end
   end

   // Timeout tracking: counts consecutive wait cycles, flag is sticky until reset.
   always_comb begin
      tmo_cnt_d     = {CNT_W{1'b0}};
      mem_timeout_d = mem_timeout_q;
      if (memwait_s) begin
         if (tmo_cnt_q != {CNT_W{1'b1}}) begin
            tmo_cnt_d = tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            tmo_cnt_d = tmo_cnt_q;
         end
         if (tmo_cnt_d == CNT_W'(MEM_TMO)) begin
            mem_timeout_d = 1'b1;
         end else begin
            mem_timeout_d = mem_timeout_q;
         end
      end else begin
         tmo_cnt_d = {CNT_W{1'b0}};
      end
   end

   // State, bubble and timeout registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         lu_cnt_q      <= 2'd0;
         tmo_cnt_q     <= {CNT_W{1'b0}};
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lu_cnt_q      <= lu_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign bus.ctrl_stall  = rst & ctrl_stall_s;
   assign bus.pc_hold     = rst & pc_hold_s;
   assign bus.if_id_hold  = rst & if_id_hold_s;
   assign bus.if_id_flush = rst & if_id_flush_s;
   assign bus.id_ex_hold  = rst & id_ex_hold_s;
   assign bus.ex_mem_hold = rst & ex_mem_hold_s;
   assign bus.mem_timeout = mem_timeout_q;

   sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (bus.pc_hold),
      .clr_i (1'b0),
      .cnt_o (bus.stall_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (bus.if_id_flush),
      .clr_i (1'b0),
      .cnt_o (bus.flush_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench: three schedulers (1, 2 and 3 load-use bubbles) share one directed
// stimulus stream and are checked every cycle against a rule-level model.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
   logic       ex_mem_read = 1'b0, ex_br_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

   logic [5:0] act_ctl [3];
   logic [3:0] act_sc  [3];
   logic [3:0] act_fc  [3];
   logic       act_to  [3];

   int total = 0;
   int bad   = 0;

   int m_bub [3];
   int m_inw [3];
   int m_wc  [3];
   int m_to  [3];
   int m_sc  [3];
   int m_fc  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_ctrl_if #(.CNT_W(4)) hif ();
      assign hif.id_rs1      = id_rs1;
      assign hif.id_rs2      = id_rs2;
      assign hif.ex_rd       = ex_rd;
      assign hif.ex_mem_read = ex_mem_read;
      assign hif.ex_br_taken = ex_br_taken;
      assign hif.mem_req     = mem_req;
      assign hif.mem_ack     = mem_ack;
      hazard_ctrl #(.LU_BUBBLES(g + 1), .MEM_TMO(3), .CNT_W(4)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (hif.slave)
      );
      assign act_ctl[g] = {hif.ctrl_stall, hif.pc_hold, hif.if_id_hold,
                           hif.if_id_flush, hif.id_ex_hold, hif.ex_mem_hold};
      assign act_sc[g]  = hif.stall_cnt;
      assign act_fc[g]  = hif.flush_cnt;
      assign act_to[g]  = hif.mem_timeout;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: bubbles still owed, whether a memory wait is being released, wait length.
   task automatic model_check();
      for (int k = 0; k < 3; k++) begin
         logic       mw, hz;
         logic [5:0] e;
         mw = mem_req & ~mem_ack;
         hz = ex_mem_read && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
         e  = 6'b000000;
         if (!rst) begin
            m_bub[k] = 0; m_inw[k] = 0; m_wc[k] = 0; m_to[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else if (mw) begin
            e = 6'b011011;
         end else if (m_inw[k] != 0) begin
            e = ex_br_taken ? 6'b100100 : 6'b000000;
         end else if (ex_br_taken) begin
            e = 6'b100100;
         end else if (m_bub[k] > 0 || hz) begin
            e = 6'b111000;
         end
         chk($sformatf("ctl[%0d]", k), int'(act_ctl[k]), int'(e));
         chk($sformatf("cnts[%0d]", k), {24'd0, act_sc[k], act_fc[k]}, m_sc[k] * 16 + m_fc[k]);
         chk($sformatf("tmo[%0d]", k), int'(act_to[k]), m_to[k]);
         if (rst) begin
            if (mw) begin
               if (m_bub[k] == 0) m_inw[k] = 1;
            end else if (m_inw[k] != 0) begin
               m_inw[k] = 0;
            end else if (ex_br_taken) begin
               m_bub[k] = 0;
            end else if (m_bub[k] > 0) begin
               m_bub[k]--;
            end else if (hz) begin
               m_bub[k] = k;
            end
            if (mw) begin
               m_wc[k] = (m_wc[k] < 15) ? m_wc[k] + 1 : 15;
               if (m_wc[k] >= 3) m_to[k] = 1;
            end else begin
               m_wc[k] = 0;
            end
            if (e[4]) m_sc[k] = (m_sc[k] < 15) ? m_sc[k] + 1 : 15;
            if (e[2]) m_fc[k] = (m_fc[k] < 15) ? m_fc[k] + 1 : 15;
         end
      end
   endtask

   task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic rq, input logic ak,
                       input logic rmid);
      @(posedge clk);
      #1;
      id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
      ex_mem_read = mr; ex_br_taken = br; mem_req = rq; mem_ack = ak;
      if (rmid) begin
         #2;
         rst = 1'b0;
      end
      @(negedge clk);
      model_check();
   endtask

   task automatic idle();
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic haz();
      step(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mwait(input logic ak);
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, ak, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      chk("rst_ctl", int'(act_ctl[0]), 0);
      chk("rst_cnt", int'(act_sc[0]), 0);
      rst = 1'b1;
   endtask

   initial begin
      do_reset();
      // Single-bubble load-use on rs1.
      idle();
      haz();
      chk("t1_stall", int'(act_ctl[0]), 6'b111000);
      idle();
      chk("t1_free", int'(act_ctl[0]), 0);
      chk("t1_scnt", int'(act_sc[0]), 1);
      // x0 destination never stalls; two bubbles on an rs2 match.
      do_reset();
      step(5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_x0", int'(act_ctl[1]), 0);
      step(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("t2_bub2", int'(act_ctl[1][5]), 1);
      idle();
      chk("t2_done", int'(act_ctl[1][5]), 0);
      chk("t2_scnt", int'(act_sc[1]), 2);
      // Taken branch overrides a simultaneous hazard.
      do_reset();
      step(5'd5, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_ctl", int'(act_ctl[0]), 6'b100100);
      idle();
      chk("t3_fcnt", int'(act_fc[0]), 1);
      // Memory wait interrupts a three-bubble load-use stall.
      do_reset();
      haz();
      for (int i = 0; i < 4; i++) begin
         mwait(1'b0);
         chk("t4_wait", int'(act_ctl[2]), 6'b011011);
      end
      mwait(1'b1);
      chk("t4_resume1", int'(act_ctl[2]), 6'b111000);
      idle();
      chk("t4_resume2", int'(act_ctl[2]), 6'b111000);
      idle();
      chk("t4_free", int'(act_ctl[2]), 0);
      chk("t4_scnt", int'(act_sc[2]), 7);
      // Timeout after three wait cycles, sticky across the ack.
      do_reset();
      mwait(1'b0);
      mwait(1'b0);
      mwait(1'b0);
      chk("t5_pre", int'(act_to[0]), 0);
      mwait(1'b1);
      chk("t5_set", int'(act_to[0]), 1);
      idle();
      chk("t5_sticky", int'(act_to[0]), 1);
      do_reset();
      chk("t5_clr", int'(act_to[0]), 0);
      // Stall counter saturation, then reset in the middle of a stall.
      for (int i = 0; i < 20; i++) begin
         haz();
         idle();
      end
      chk("t6_sat", int'(act_sc[0]), 15);
      haz();
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_rst_ctl", int'(act_ctl[2]), 0);
      chk("t6_rst_cnt", int'(act_sc[2]), 0);
      rst = 1'b1;
      idle();
      chk("t6_noreplay", int'(act_ctl[2]), 0);
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
